mem_stream_ctrl: RTL

- Stream-side controller that sits directly upstream of the dual-port RAM wrapper and drives both of its ports.
- Port 0 is a write port. It loads a valid/ready input stream into consecutive RAM addresses.
- Port 1 is a read port. It streams a consecutive address range out on a valid/ready output, absorbing the RAM's 1-cycle registered read latency with a 2-entry output buffer.
- Used to load and unload key/syndrome buffers in the McEliece datapath without stalls.

---
 rtl/mem_stream_ctrl_pkg.sv | 24 ++
 rtl/mem_stream_ctrl_skid.sv | 47 ++++
 rtl/mem_stream_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_stream_ctrl_pkg.sv
// Shared definitions for the stream-side RAM controller: state encodings and
// the address wrap helper used by both ports.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mem_stream_ctrl_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RUN  = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

  // Explicit compare so depths that are not a power of two still wrap correctly
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/mem_stream_ctrl_skid.sv
// Two-entry output buffer absorbing the RAM read latency; head entry drives
// the output stream and stays stable until popped.
module mem_stream_ctrl_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail_data;

  // Push lands in the head when that slot is free after any pop, else the tail
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_data <= '0;
      tail_data <= '0;
      count     <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head_data <= push_data;
          else               tail_data <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_data;
            tail_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_ctrl.sv
// Drives both ports of the dual-port RAM: port 0 loads an input stream into
// consecutive addresses, port 1 streams a consecutive range back out.
module mem_stream_ctrl
  import mem_stream_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = `CLOG2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W:0]   wr_len,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_busy,
  output logic              wr_done,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [WIDTH-1:0]  mem_data_0,
  output logic [ADDR_W-1:0] mem_address_0,
  output logic              mem_wren_0,
  output logic [ADDR_W-1:0] mem_address_1,
  input  logic [WIDTH-1:0]  mem_q_1
);

  localparam logic [ADDR_W:0] LEN_ONE = 1;

  wr_state_t         wr_state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   wr_rem;

  assign in_ready      = (wr_state == W_RUN);
  assign wr_busy       = (wr_state == W_RUN);
  assign mem_wren_0    = in_valid & in_ready;
  assign mem_data_0    = in_data;
  assign mem_address_0 = wr_addr;

  // Write side: one RAM write per accepted input beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_addr  <= '0;
      wr_rem   <= '0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      if (wr_state == W_IDLE) begin
        if (wr_start) begin
          if (wr_len == '0) begin
            wr_done <= 1'b1;
          end else begin
            wr_state <= W_RUN;
            wr_addr  <= wr_base;
            wr_rem   <= wr_len;
          end
        end
      end else if (in_valid) begin
        wr_addr <= ADDR_W'(wrap_inc(32'(wr_addr), DEPTH));
        wr_rem  <= wr_rem - LEN_ONE;
        if (wr_rem == LEN_ONE) begin
          wr_state <= W_IDLE;
          wr_done  <= 1'b1;
        end
      end
    end
  end

  rd_state_t       rd_state;
  logic [ADDR_W:0] iss_rem;
  logic [ADDR_W:0] pop_rem;
  logic            inflight;
  logic [1:0]      buf_count;
  logic [2:0]      occupancy;
  logic            pop;
  logic            issue;

  assign pop       = out_valid & out_ready;
  assign out_valid = (buf_count != 2'd0);
  assign rd_busy   = (rd_state == R_RUN);
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight};
  // Words already buffered or in flight must fit the two slots after this cycle's pop
  assign issue     = (rd_state == R_RUN) && (iss_rem != '0) &&
                     (occupancy < (3'd2 + {2'b00, pop}));

  // Read side: issue addresses ahead, finish when the last word leaves the buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state      <= R_IDLE;
      mem_address_1 <= '0;
      iss_rem       <= '0;
      pop_rem       <= '0;
      inflight      <= 1'b0;
      rd_done       <= 1'b0;
    end else begin
      rd_done  <= 1'b0;
      inflight <= issue;
      if (rd_state == R_IDLE) begin
        if (rd_start) begin
          if (rd_len == '0) begin
            rd_done <= 1'b1;
          end else begin
            rd_state      <= R_RUN;
            mem_address_1 <= rd_base;
            iss_rem       <= rd_len;
            pop_rem       <= rd_len;
          end
        end
      end else begin
        if (issue) begin
          mem_address_1 <= ADDR_W'(wrap_inc(32'(mem_address_1), DEPTH));
          iss_rem       <= iss_rem - LEN_ONE;
        end
        if (pop) begin
          pop_rem <= pop_rem - LEN_ONE;
          if (pop_rem == LEN_ONE) begin
            rd_state <= R_IDLE;
            rd_done  <= 1'b1;
          end
        end
      end
    end
  end

  mem_stream_ctrl_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (mem_q_1),
    .pop       (pop),
    .head_data (out_data),
    .count     (buf_count)
  );

endmodule
